// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: scan-out reads always win; pixel writes are posted
// into a small FIFO and drained in cycles with no read request.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_LIM = 1024
) (
  input  logic                          CLK,
  input  logic                          i_Reset,
  input  logic                          i_Rd_Req,
  input  logic [ADDR_W-1:0]             i_Rd_Addr,
  output logic                          o_Rd_Valid,
  output logic [DATA_W-1:0]             o_Rd_Data,
  input  logic                          i_Wr_Valid,
  output logic                          o_Wr_Ready,
  input  logic [ADDR_W-1:0]             i_Wr_Addr,
  input  logic [DATA_W-1:0]             i_Wr_Data,
  output logic                          o_Mem_En,
  output logic                          o_Mem_We,
  output logic [ADDR_W-1:0]             o_Mem_Addr,
  output logic [DATA_W-1:0]             o_Mem_Wdata,
  input  logic [DATA_W-1:0]             i_Mem_Rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Starved
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned StvW = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] DepthC     = CntW'(FIFO_DEPTH);
  localparam logic [StvW-1:0] StarveLimC = StvW'(STARVE_LIM);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              wr_ready_q;
  logic              push, pop, full, empty;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [RD_LAT-1:0] rd_pipe_q;
  logic              rd_issue;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [StvW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              starved_q;

  always_comb begin
    full  = (count_q == DepthC);
    empty = (count_q == '0);
    push  = i_Wr_Valid & wr_ready_q;
    pop   = ~i_Rd_Req & ~empty;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if (full && i_Rd_Req && (starve_cnt_q != StarveLimC)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // A read command currently on the port; its data returns RD_LAT cycles later.
    rd_issue = mem_en_q & ~mem_we_q;
  end

  // Payload storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_Wr_Addr;
      fifo_data_q[wr_ptr_q] <= i_Wr_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_ready_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pipe_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      starve_cnt_q <= '0;
      starved_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      // Based on the next count so a push can never land on a full FIFO.
      wr_ready_q <= (count_d != DepthC);

      mem_en_q <= i_Rd_Req | ~empty;
      mem_we_q <= ~i_Rd_Req & ~empty;
      if (i_Rd_Req) begin
        mem_addr_q <= i_Rd_Addr;
      end else if (pop) begin
        mem_addr_q  <= fifo_addr_q[rd_ptr_q];
        mem_wdata_q <= fifo_data_q[rd_ptr_q];
      end

      rd_pipe_q  <= (rd_pipe_q << 1) | RD_LAT'(rd_issue);
      rd_valid_q <= rd_pipe_q[RD_LAT-1];
      if (rd_pipe_q[RD_LAT-1]) rd_data_q <= i_Mem_Rdata;

      starve_cnt_q <= starve_cnt_d;
      starved_q    <= starved_q | (starve_cnt_d == StarveLimC);
    end
  end

  assign o_Wr_Ready   = wr_ready_q;
  assign o_Mem_En     = mem_en_q;
  assign o_Mem_We     = mem_we_q;
  assign o_Mem_Addr   = mem_addr_q;
  assign o_Mem_Wdata  = mem_wdata_q;
  assign o_Rd_Valid   = rd_valid_q;
  assign o_Rd_Data    = rd_data_q;
  assign o_Fifo_Count = count_q;
  assign o_Starved    = starved_q;

endmodule
